isp_raw_reader: RTL and testbench

//  Front stage of isp_top, directly upstream of black-level/crop processing.
//  - Fetches a stored raw Bayer frame from the 64-bit word-addressed RAM.
//  - Applies the crop window (top_margin, left_margin, crop_height, crop_width).
//  - Unpacks 4 pixels per word into a one-pixel-per-cycle valid/ready stream.
//  - Each pixel carries frame/line markers and its Bayer phase.

---
 rtl/isp_pkg.sv | 32 +++
 rtl/isp_word_fifo.sv | 65 ++++++
 rtl/isp_raw_reader.sv | 269 ++++++++++++++++++++++++++
 tb/tb_isp_raw_reader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : isp_pkg
//  Purpose  : Shared types for the raw-frame reader: the 64-bit RAM word,
//             the fetched-word FIFO entry and the fetch FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package isp_pkg;

    localparam int PIXELS_PER_WORD = 4;

    typedef logic [63:0] raw_word_t;

    // One fetched RAM word plus the lane range to emit and its frame position.
    typedef struct packed {
        raw_word_t  word;
        logic [1:0] lane_lo;
        logic [1:0] lane_hi;
        logic       row_first;
        logic       row_last;
        logic       frame_first;
        logic       frame_last;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/isp_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : isp_word_fifo
//  Purpose  : Synchronous FIFO of fetch entries with first-word fall-through
//             head output. A push on a full FIFO is accepted only together
//             with a pop, leaving occupancy unchanged.
//  Revision : 1.0  initial release
// ============================================================================
module isp_word_fifo
    import isp_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty
);

    localparam int c_AW = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (c_AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr];

    // Storage array: written on every accepted push, never reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/isp_raw_reader.sv
`default_nettype none
// ============================================================================
//  Module   : isp_raw_reader
//  Purpose  : Fetches a cropped window of a packed raw Bayer frame from a
//             64-bit word RAM and streams it one pixel per handshake with
//             sof/eol/eof markers and Bayer phase.
//  Revision : 1.0  initial release
// ============================================================================
module isp_raw_reader
    import isp_pkg::*;
#(
    parameter int PIXEL_WIDTH = 16,
    parameter int FIFO_DEPTH  = 4
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   new_frame,
    input  logic [31:0]            frame_base_addr,
    input  logic [15:0]            raw_width,
    input  logic [9:0]             top_margin,
    input  logic [9:0]             left_margin,
    input  logic [15:0]            crop_height,
    input  logic [15:0]            crop_width,
    output logic [31:0]            read_address,
    input  logic [63:0]            read_data,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [PIXEL_WIDTH-1:0] pix_data,
    output logic                   pix_sof,
    output logic                   pix_eol,
    output logic                   pix_eof,
    output logic [1:0]             pix_phase,
    output logic                   busy,
    output logic                   frame_done
);

    // ---------------- fetch side ----------------
    fetch_state_t r_state, w_state_next;
    logic [31:0]  r_read_address;
    logic [31:0]  r_row_start;      // address of the first cropped word of the current row
    logic [31:0]  r_stride;         // words per stored row
    logic [14:0]  r_span;           // last word index within a cropped row
    logic [14:0]  r_wcol;
    logic [1:0]   r_lane_lo_cfg;
    logic [1:0]   r_lane_hi_cfg;
    logic [15:0]  r_rows_left;
    logic [9:0]   r_skip;           // rows still to step over before row top_margin
    logic         r_first_row;
    logic         r_addr_valid;     // read_address points at a word still to be pushed

    logic [16:0]  w_last_col;
    logic [14:0]  w_word_lo;
    logic [14:0]  w_word_hi;
    logic [31:0]  w_first_addr;
    logic [31:0]  w_next_row_start;
    logic         w_row_end;
    logic         w_frame_end;
    logic         w_push;
    fetch_entry_t w_push_entry;
    logic         w_unused_bits;

    // ---------------- FIFO / unpack side ----------------
    fetch_entry_t w_head;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_load;
    logic         w_emit;
    logic [1:0]   w_lane;
    logic         w_last_lane;
    logic         w_sof_n;
    logic         w_eol_n;
    logic         w_eof_n;
    raw_word_t    w_shifted;
    logic         w_eof_accept;

    logic [1:0]             r_lane;
    logic                   r_lane_busy;
    logic                   r_row_par;
    logic                   r_pix_valid;
    logic [PIXEL_WIDTH-1:0] r_pix_data;
    logic                   r_pix_sof;
    logic                   r_pix_eol;
    logic                   r_pix_eof;
    logic [1:0]             r_pix_phase;
    logic                   r_frame_done;

    assign w_unused_bits    = &{1'b0, raw_width[1:0]};

    assign w_last_col       = 17'(left_margin) + 17'(crop_width) - 17'd1;
    assign w_word_lo        = 15'(left_margin[9:2]);
    assign w_word_hi        = w_last_col[16:2];
    assign w_first_addr     = frame_base_addr + 32'(w_word_lo);
    assign w_next_row_start = r_row_start + r_stride;
    assign w_row_end        = (r_wcol == r_span);
    assign w_frame_end      = w_row_end && (r_rows_left == 16'd1);
    assign w_eof_accept     = r_pix_valid && pix_ready && r_pix_eof;

    // Fetch FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Fetch FSM next state, push strobe and the entry built from the RAM word.
    always_comb begin
        w_state_next             = r_state;
        w_push                   = 1'b0;
        w_push_entry.word        = read_data;
        w_push_entry.lane_lo     = (r_wcol == '0) ? r_lane_lo_cfg : 2'd0;
        w_push_entry.lane_hi     = w_row_end ? r_lane_hi_cfg : 2'd3;
        w_push_entry.row_first   = (r_wcol == '0);
        w_push_entry.row_last    = w_row_end;
        w_push_entry.frame_first = (r_wcol == '0) && r_first_row;
        w_push_entry.frame_last  = w_frame_end;
        case (r_state)
            IDLE: begin
                if (new_frame) w_state_next = FETCH;
            end
            FETCH: begin
                if (r_addr_valid && !w_full) begin
                    w_push = 1'b1;
                    if (w_frame_end) w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_eof_accept) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Config latch and address walk: rows advance by adding the stride, never multiplying.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_address <= '0;
            r_row_start    <= '0;
            r_stride       <= '0;
            r_span         <= '0;
            r_wcol         <= '0;
            r_lane_lo_cfg  <= '0;
            r_lane_hi_cfg  <= '0;
            r_rows_left    <= '0;
            r_skip         <= '0;
            r_first_row    <= 1'b0;
            r_addr_valid   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (new_frame) begin
                r_row_start   <= w_first_addr;
                r_stride      <= 32'(raw_width[15:2]);
                r_span        <= w_word_hi - w_word_lo;
                r_wcol        <= '0;
                r_lane_lo_cfg <= left_margin[1:0];
                r_lane_hi_cfg <= w_last_col[1:0];
                r_rows_left   <= crop_height;
                r_first_row   <= 1'b1;
                r_skip        <= top_margin;
                if (top_margin == '0) begin
                    r_read_address <= w_first_addr;
                    r_addr_valid   <= 1'b1;
                end else begin
                    r_addr_valid   <= 1'b0;
                end
            end
        end else if (r_state == FETCH) begin
            if (r_skip != '0) begin
                r_row_start <= w_next_row_start;
                r_skip      <= r_skip - 10'd1;
                if (r_skip == 10'd1) begin
                    r_read_address <= w_next_row_start;
                    r_addr_valid   <= 1'b1;
                end
            end else if (w_push) begin
                if (w_row_end) begin
                    r_wcol      <= '0;
                    r_first_row <= 1'b0;
                    r_rows_left <= r_rows_left - 16'd1;
                    if (w_frame_end) begin
                        r_addr_valid <= 1'b0;
                    end else begin
                        r_row_start    <= w_next_row_start;
                        r_read_address <= w_next_row_start;
                    end
                end else begin
                    r_wcol         <= r_wcol + 15'd1;
                    r_read_address <= r_read_address + 32'd1;
                end
            end
        end
    end

    isp_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (w_push_entry),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Unpacker selection: current lane of the head entry and its markers.
    always_comb begin
        w_load      = !r_pix_valid || pix_ready;
        w_emit      = w_load && !w_empty;
        w_lane      = r_lane_busy ? r_lane : w_head.lane_lo;
        w_last_lane = (w_lane == w_head.lane_hi);
        w_pop       = w_emit && w_last_lane;
        w_sof_n     = w_head.frame_first && !r_lane_busy;
        w_eol_n     = w_head.row_last && w_last_lane;
        w_eof_n     = w_eol_n && w_head.frame_last;
        w_shifted   = w_head.word << (32'(w_lane) * PIXEL_WIDTH);
    end

    // Output register: reloads only when empty or accepted, so stalls hold it stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_valid  <= 1'b0;
            r_pix_data   <= '0;
            r_pix_sof    <= 1'b0;
            r_pix_eol    <= 1'b0;
            r_pix_eof    <= 1'b0;
            r_pix_phase  <= '0;
            r_lane       <= '0;
            r_lane_busy  <= 1'b0;
            r_row_par    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_eof_accept;
            if (r_state == IDLE && new_frame) begin
                r_row_par <= top_margin[0];
            end else if (w_emit && w_eol_n) begin
                r_row_par <= ~r_row_par;
            end
            if (w_load) begin
                r_pix_valid <= w_emit;
            end
            if (w_emit) begin
                r_pix_data  <= w_shifted[63 -: PIXEL_WIDTH];
                r_pix_sof   <= w_sof_n;
                r_pix_eol   <= w_eol_n;
                r_pix_eof   <= w_eof_n;
                r_pix_phase <= {r_row_par, w_lane[0]};
                if (w_last_lane) begin
                    r_lane_busy <= 1'b0;
                end else begin
                    r_lane      <= w_lane + 2'd1;
                    r_lane_busy <= 1'b1;
                end
            end
        end
    end

    assign read_address = r_read_address;
    assign pix_valid    = r_pix_valid;
    assign pix_data     = r_pix_data;
    assign pix_sof      = r_pix_sof;
    assign pix_eol      = r_pix_eol;
    assign pix_eof      = r_pix_eof;
    assign pix_phase    = r_pix_phase;
    assign busy         = (r_state != IDLE);
    assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_isp_raw_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_isp_raw_reader
//  Purpose  : Self-checking bench for isp_raw_reader against a frame-level
//             reference built from nested row/column loops.
//  Revision : 1.0  initial release
// ============================================================================
module tb_isp_raw_reader;

    typedef struct packed {
        logic [15:0] d;
        logic        sof;
        logic        eol;
        logic        eof;
        logic [1:0]  ph;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_frame = 1'b0;
    logic [31:0] frame_base_addr = '0;
    logic [15:0] raw_width = '0;
    logic [9:0]  top_margin = '0;
    logic [9:0]  left_margin = '0;
    logic [15:0] crop_height = '0;
    logic [15:0] crop_width = '0;
    logic [31:0] read_address;
    logic [63:0] read_data;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [15:0] pix_data;
    logic        pix_sof, pix_eol, pix_eof;
    logic [1:0]  pix_phase;
    logic        busy, frame_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_origin = '0;
    logic [15:0] mem_salt = '0;
    int          ready_pct = 100;

    pix_t        exp_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] got_addr[$];
    logic [15:0] got_data[$];
    logic [1:0]  got_ph[$];
    logic [31:0] last_addr = '0;
    bit          armed = 1'b0;
    bit          expect_done = 1'b0;
    bit          stall_hold = 1'b0;
    pix_t        held;
    int          done_cnt = 0;
    int          done0 = 0;

    isp_raw_reader #(.PIXEL_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .new_frame(new_frame),
        .frame_base_addr(frame_base_addr), .raw_width(raw_width),
        .top_margin(top_margin), .left_margin(left_margin),
        .crop_height(crop_height), .crop_width(crop_width),
        .read_address(read_address), .read_data(read_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .pix_phase(pix_phase), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // RAM content: pixel value is a ramp over the word offset from the frame origin.
    function automatic logic [15:0] pix_val(input logic [31:0] a, input logic [1:0] k,
                                            input logic [31:0] org, input logic [15:0] salt);
        logic [31:0] t;
        t = ((a - org) << 2) + 32'(k);
        return t[15:0] ^ salt;
    endfunction

    assign read_data = {pix_val(read_address, 2'd0, mem_origin, mem_salt),
                        pix_val(read_address, 2'd1, mem_origin, mem_salt),
                        pix_val(read_address, 2'd2, mem_origin, mem_salt),
                        pix_val(read_address, 2'd3, mem_origin, mem_salt)};

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, want, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        pix_ready = ($urandom_range(99) < ready_pct);
    end

    // Single compare process: stalls, handshakes, frame_done and address trace.
    always @(negedge clk) begin
        pix_t cur;
        pix_t e;
        if (armed && rst_n) begin
            cur = '{pix_data, pix_sof, pix_eol, pix_eof, pix_phase};
            if (frame_done) done_cnt++;
            if (expect_done) begin
                chk(frame_done && !busy, "frame_done_busy", {frame_done, busy}, 2'b10);
                expect_done = 1'b0;
            end
            if (stall_hold) begin
                chk(pix_valid && cur == held, "stall_stable", {pix_valid, cur}, {1'b1, held});
                stall_hold = 1'b0;
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_pixel", cur, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(cur == e, "pixel", cur, e);
                    got_data.push_back(pix_data);
                    got_ph.push_back(pix_phase);
                    if (pix_eof) expect_done = 1'b1;
                end
            end else if (pix_valid) begin
                stall_hold = 1'b1;
                held = cur;
            end
            if (busy && read_address != last_addr) begin
                got_addr.push_back(read_address);
                last_addr = read_address;
            end
        end
    end

    task automatic launch(input logic [31:0] b, input int rw, input int top, input int left,
                          input int h, input int w, input logic [15:0] salt, input int pct);
        pix_t e;
        logic [31:0] a;
        exp_q.delete(); exp_addr.delete(); got_addr.delete(); got_data.delete(); got_ph.delete();
        for (int r = top; r < top + h; r++)
            for (int wc = left / 4; wc <= (left + w - 1) / 4; wc++)
                exp_addr.push_back(b + 32'(r * (rw / 4) + wc));
        for (int r = top; r < top + h; r++) begin
            for (int c = left; c < left + w; c++) begin
                a     = b + 32'(r * (rw / 4) + c / 4);
                e.d   = pix_val(a, 2'(c % 4), b, salt);
                e.sof = (r == top) && (c == left);
                e.eol = (c == left + w - 1);
                e.eof = e.eol && (r == top + h - 1);
                e.ph  = {r[0], c[0]};
                exp_q.push_back(e);
            end
        end
        mem_origin = b;
        mem_salt   = salt;
        ready_pct  = pct;
        @(negedge clk);
        frame_base_addr = b;
        raw_width       = 16'(rw);
        top_margin      = 10'(top);
        left_margin     = 10'(left);
        crop_height     = 16'(h);
        crop_width      = 16'(w);
        new_frame       = 1'b1;
        last_addr       = read_address;
        done0           = done_cnt;
        expect_done     = 1'b0;
        stall_hold      = 1'b0;
        armed           = 1'b1;
        @(posedge clk);
        #1;
        new_frame       = 1'b0;
        // Scramble the config inputs: the running frame must use its latched copy.
        frame_base_addr = $urandom;
        raw_width       = 16'($urandom);
        top_margin      = 10'($urandom);
        left_margin     = 10'($urandom);
        crop_height     = 16'($urandom);
        crop_width      = 16'($urandom);
    endtask

    task automatic finish_frame(input bit mid_pulse);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || expect_done || busy) && i < 3000) begin
            @(posedge clk);
            #1;
            i++;
            if (mid_pulse && i == 6) new_frame = 1'b1;
            if (mid_pulse && i == 7) new_frame = 1'b0;
        end
        new_frame = 1'b0;
        chk(i < 3000, "frame_timeout", 64'(i), 3000);
        @(negedge clk);
        chk(done_cnt - done0 == 1, "done_count", 64'(done_cnt - done0), 1);
        chk(got_addr.size() == exp_addr.size(), "addr_count", got_addr.size(), exp_addr.size());
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++)
            chk(got_addr[k] == exp_addr[k], "read_addr", got_addr[k], exp_addr[k]);
        armed = 1'b0;
    endtask

    localparam logic [31:0] c_B = 32'h0000_0100;

    initial begin
        logic [31:0] b;
        int rw, lf, wd;
        #3;
        chk(read_address == 0, "reset_addr", read_address, 0);
        chk({pix_valid, pix_data, pix_sof, pix_eol, pix_eof, pix_phase, busy, frame_done} == '0,
            "reset_outputs", {pix_valid, pix_data, pix_sof, pix_eol, pix_eof, pix_phase, busy, frame_done}, 0);
        #20;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Ramp frame, always ready.
        launch(c_B, 16, 1, 2, 3, 5, 16'h0, 100);
        finish_frame(1'b0);
        chk(got_data.size() == 15, "ramp_count", got_data.size(), 15);
        if (got_data.size() == 15) begin
            chk(got_data[0] == 16'h12, "ramp_first", got_data[0], 16'h12);
            chk(got_data[4] == 16'h16, "ramp_row0_end", got_data[4], 16'h16);
            chk(got_data[5] == 16'h22, "ramp_row1_start", got_data[5], 16'h22);
            chk(got_data[14] == 16'h36, "ramp_last", got_data[14], 16'h36);
        end
        if (got_addr.size() == 6) begin
            chk(got_addr[0] == c_B + 4, "ramp_addr0", got_addr[0], c_B + 4);
            chk(got_addr[1] == c_B + 5, "ramp_addr1", got_addr[1], c_B + 5);
            chk(got_addr[5] == c_B + 13, "ramp_addr5", got_addr[5], c_B + 13);
        end

        // Same frame with random backpressure, plus an ignored mid-frame new_frame.
        launch(c_B, 16, 1, 2, 3, 5, 16'h0, 50);
        finish_frame(1'b1);
        // Replay after the ignored pulse.
        launch(c_B, 16, 1, 2, 3, 5, 16'h0, 50);
        finish_frame(1'b0);

        // Aligned frame.
        launch(32'h0000_0200, 8, 0, 0, 2, 8, 16'h0, 100);
        finish_frame(1'b0);
        chk(got_data.size() == 16, "aligned_count", got_data.size(), 16);
        if (got_ph.size() == 16) begin
            chk(got_ph[0] == 2'b00 && got_ph[1] == 2'b01, "aligned_ph_row0", {got_ph[0], got_ph[1]}, 4'b0001);
            chk(got_ph[8] == 2'b10 && got_ph[9] == 2'b11, "aligned_ph_row1", {got_ph[8], got_ph[9]}, 4'b1011);
        end

        // Single-pixel rows.
        launch(32'h0000_0300, 8, 0, 3, 2, 1, 16'h5a5a, 100);
        finish_frame(1'b0);
        if (got_ph.size() == 2)
            chk(got_ph[0] == 2'b01 && got_ph[1] == 2'b11, "width1_phase", {got_ph[0], got_ph[1]}, 4'b0111);
        else
            chk(1'b0, "width1_count", got_ph.size(), 2);

        // Reset in the middle of a row.
        launch(c_B, 16, 1, 2, 3, 5, 16'h0, 100);
        repeat (4) @(posedge clk);
        armed = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk({pix_valid, busy} == 2'b00, "midreset_valid_busy", {pix_valid, busy}, 0);
        chk(read_address == 0, "midreset_addr", read_address, 0);
        exp_q.delete();
        expect_done = 1'b0;
        stall_hold  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        launch(c_B, 16, 1, 2, 3, 5, 16'h0, 70);
        finish_frame(1'b0);

        // Random crop windows and backpressure.
        for (int i = 0; i < 8; i++) begin
            rw = 4 * $urandom_range(1, 8);
            lf = $urandom_range(0, rw - 1);
            wd = $urandom_range(1, rw - lf);
            b  = 32'h1000 * 32'(i + 1) + 32'($urandom_range(0, 255));
            launch(b, rw, $urandom_range(0, 3), lf, $urandom_range(1, 4), wd,
                   16'($urandom), (i % 3 == 0) ? 100 : ((i % 3 == 1) ? 60 : 25));
            finish_frame(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
